// File: rtl/rr_encoder8_3_pkg.sv
// Shared constants, state encoding and helpers for the round-robin 8-to-3 encoder.
package rr_encoder8_3_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // One-hot mask for a 3-bit index; used to clear the granted pending bit.
  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] m;
    m    = '0;
    m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_encoder8_3_if.sv
// Request/offer bus between request sources, the encoder and the index consumer.
interface rr_encoder8_3_if;
  import rr_encoder8_3_pkg::*;

  logic [N_REQ-1:0] req;
  logic             en;
  logic             ack;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic [N_REQ-1:0] pending;

  // Driver side: raises requests, gates offers, accepts them.
  modport master (
    output req, en, ack,
    input  idx, valid, pending
  );

  // Encoder side.
  modport slave (
    input  req, en, ack,
    output idx, valid, pending
  );

endinterface

// File: rtl/rr_encoder8_3_prio_enc8_3.sv
// Fixed-priority 8-to-3 encoder: the lowest set bit wins.
module prio_enc8_3
  import rr_encoder8_3_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  output logic [IDX_W-1:0] out,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last to overwrite out.
  always_comb begin
    out = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (in[i]) begin
        out = IDX_W'(i);
      end
    end
  end

  assign any = |in;

endmodule

// File: rtl/rr_encoder8_3.sv
// Round-robin 8-to-3 encoder: sticky request collection, one registered offer at a time.
module rr_encoder8_3
  import rr_encoder8_3_pkg::*;
#(
  parameter logic [IDX_W-1:0] RST_PTR = 3'd0
) (
  input  logic            clk,
  input  logic            rst,
  rr_encoder8_3_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic             r_valid;
  logic             w_valid_next;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] w_pending_next;

  logic [N_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_enc_out;
  logic             w_enc_any;
  logic [IDX_W-1:0] w_winner;
  logic             w_ack_fire;
  logic [N_REQ-1:0] w_clr;

  // Rotate pending right by ptr so the ptr position lands on bit 0 of the encoder.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    localparam logic [IDX_W-1:0] OFS = IDX_W'(gi);
    assign w_rot[gi] = r_pending[r_ptr + OFS];
  end

  prio_enc8_3 u_prio_enc (
    .in  (w_rot),
    .out (w_enc_out),
    .any (w_enc_any)
  );

  // Undo the rotation; 3-bit addition wraps modulo 8.
  assign w_winner = w_enc_out + r_ptr;

  // Handshake completes only while an offer is live; a stray ack is ignored.
  assign w_ack_fire = r_valid & bus.ack;
  assign w_clr      = w_ack_fire ? onehot8(r_idx) : '0;

  // A req on the granted line in the ack cycle re-arms it as a fresh request.
  assign w_pending_next = (r_pending & ~w_clr) | bus.req;

  // Next-state and registered-output values for the offer FSM.
  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_valid;
    w_idx_next   = r_idx;
    w_ptr_next   = r_ptr;
    unique case (r_state)
      IDLE: begin
        w_valid_next = 1'b0;
        if (bus.en && w_enc_any) begin
          w_idx_next   = w_winner;
          w_valid_next = 1'b1;
          w_state_next = OFFER;
        end
      end
      OFFER: begin
        // Offer is held regardless of en or newer requests until accepted.
        w_valid_next = 1'b1;
        if (bus.ack) begin
          w_valid_next = 1'b0;
          w_ptr_next   = r_idx + 3'd1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_valid_next = 1'b0;
      end
    endcase
  end

  // State, pointer, offer and pending registers; reset drops any live offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= RST_PTR;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_idx     <= w_idx_next;
      r_valid   <= w_valid_next;
      r_pending <= w_pending_next;
    end
  end

  assign bus.idx     = r_idx;
  assign bus.valid   = r_valid;
  assign bus.pending = r_pending;

endmodule
